// File: rtl/rf_write_queue_if.sv
// rf_write_queue_if
// Purpose : bundles the write-back stage traffic: ALU results, load returns
//           (valid/ready), hazard-check read addresses and the RF write port.
// Modports:
//   master - upstream side: drives alu_*, ld_valid/addr/data, rd_addr1/2;
//            observes ld_ready, pend1/2, rf_*, q_count.
//   slave  - the write queue itself (opposite directions).
// Parameters: AW address width, DW data width, DEPTH load FIFO entries.
interface rf_write_queue_if #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          pend1;
    logic          pend2;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [CW-1:0] q_count;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output rd_addr1, rd_addr2,
        input  ld_ready, pend1, pend2,
        input  rf_we, rf_waddr, rf_wdata, q_count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  rd_addr1, rd_addr2,
        output ld_ready, pend1, pend2,
        output rf_we, rf_waddr, rf_wdata, q_count
    );
endinterface

// File: rtl/rf_write_queue.sv
// rf_write_queue
// Purpose : write-back stage owning the single RF write port. ALU results are
//           issued immediately (never stalled); load returns that cannot issue
//           are held in a DEPTH-entry FIFO and drained when the ALU is idle.
//           Queued destinations are reported on pend1/pend2 for hazard stalls.
// Ports   : clk   - clock, all state on posedge
//           reset - asynchronous, active-low
//           bus   - rf_write_queue_if.slave (ALU, load, read-check, RF port)
// Config  : RF_WQ_BYPASS_EN - when defined, an accepted load that finds the
//           FIFO empty and no ALU issue goes straight to rf_* (1 clk latency)
//           instead of being queued (2 clk latency).
module rf_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_queue_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    q_addr [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             rf_we_q;
    logic [AW-1:0]    rf_waddr_q;
    logic [DW-1:0]    rf_wdata_q;

    logic             alu_issue;
    logic             ld_take;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             push_vld;
    logic             pend1;
    logic             pend2;

    // Readiness depends on occupancy only; a same-cycle pop does not open a slot.
    assign bus.ld_ready = (count != FULL);

    assign alu_issue = bus.alu_valid & (bus.alu_addr != '0);
    // Address-0 loads still handshake but are discarded here.
    assign ld_take   = bus.ld_valid & bus.ld_ready & (bus.ld_addr != '0);

`ifdef RF_WQ_BYPASS_EN
    assign bypass = ld_take & (count == '0) & ~alu_issue;
`else
    assign bypass = 1'b0;
`endif

    assign push     = ld_take & ~bypass;
    assign pop      = ~alu_issue & (count != '0);
    // A load pushed alongside an ALU write to the same register is already stale.
    assign push_vld = ~(alu_issue & (bus.ld_addr == bus.alu_addr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            q_vld      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            // ALU results are younger than every queued load: squash matches.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_issue && (q_addr[i] == bus.alu_addr)) begin
                    q_vld[i] <= 1'b0;
                end
            end

            // Popped slots are cleared so pend only ever sees live entries.
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= head + PW'(1);
            end

            if (push) begin
                q_vld[tail] <= push_vld;
                tail        <= tail + PW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (alu_issue) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= bus.alu_addr;
                rf_wdata_q <= bus.alu_data;
            end else if (bypass) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= bus.ld_addr;
                rf_wdata_q <= bus.ld_data;
            end else if (pop) begin
                rf_we_q    <= q_vld[head];
                rf_waddr_q <= q_addr[head];
                rf_wdata_q <= q_data[head];
            end else begin
                rf_we_q    <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; q_vld gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= bus.ld_addr;
            q_data[tail] <= bus.ld_data;
        end
    end

    // The entry currently on rf_* has already been popped, so it is excluded.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == bus.rd_addr1)) pend1 = 1'b1;
            if (q_vld[i] && (q_addr[i] == bus.rd_addr2)) pend2 = 1'b1;
        end
        if (bus.rd_addr1 == '0) pend1 = 1'b0;
        if (bus.rd_addr2 == '0) pend2 = 1'b0;
    end

    assign bus.pend1    = pend1;
    assign bus.pend2    = pend2;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.q_count  = count;
endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    rf_write_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    rf_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: captures the write port on the negedge.
    logic [DW-1:0] rf_model [32];
    initial for (int i = 0; i < 32; i++) rf_model[i] = '0;
    always @(negedge clk) if (bus.rf_we === 1'b1) rf_model[bus.rf_waddr] = bus.rf_wdata;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [2:0]    qc;
        logic          rdy;
        logic          p1;
        logic          p2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                                input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [2:0] qc, input logic rdy, input logic p1, input logic p2);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
        v.r1 = r1; v.r2 = r2; v.we = we; v.wa = wa; v.wd = wd;
        v.qc = qc; v.rdy = rdy; v.p1 = p1; v.p2 = p2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.ld_valid  = lv; bus.ld_addr  = la; bus.ld_data  = ld;
        bus.rd_addr1  = r1; bus.rd_addr2 = r2;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic [2:0] qc);
        chk({tag, " rf_we"},    32'(bus.rf_we),    32'(we));
        chk({tag, " rf_waddr"}, 32'(bus.rf_waddr), 32'(wa));
        chk({tag, " rf_wdata"}, bus.rf_wdata,      wd);
        chk({tag, " q_count"},  32'(bus.q_count),  32'(qc));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        #2;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset ld_ready", 32'(bus.ld_ready), 1);
        chk("reset pend1", 32'(bus.pend1), 0);
        chk("reset pend2", 32'(bus.pend2), 0);
        #10 reset = 1'b1;
        step;

        //                av aa  ad        lv la  ld       r1 r2   we wa  wd       qc rdy p1 p2
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       0, 0,   0, 0,  0,       0, 1,  0, 0));
        vecs.push_back(mk(1, 5,  32'h1234, 0, 0,  0,       0, 0,   1, 5,  32'h1234,0, 1,  0, 0));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       0, 0,   0, 5,  32'h1234,0, 1,  0, 0));
        vecs.push_back(mk(1, 3,  32'h33,   1, 7,  32'hAA,  7, 0,   1, 3,  32'h33,  1, 1,  1, 0));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       7, 0,   1, 7,  32'hAA,  0, 1,  0, 0));
`ifdef RF_WQ_BYPASS_EN
        vecs.push_back(mk(0, 0,  0,        1, 8,  32'h88,  8, 0,   1, 8,  32'h88,  0, 1,  0, 0));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       8, 0,   0, 8,  32'h88,  0, 1,  0, 0));
`else
        vecs.push_back(mk(0, 0,  0,        1, 8,  32'h88,  8, 0,   0, 7,  32'hAA,  1, 1,  1, 0));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       8, 0,   1, 8,  32'h88,  0, 1,  0, 0));
`endif
        vecs.push_back(mk(1, 1,  32'h1,    1, 9,  32'h11,  9, 0,   1, 1,  32'h1,   1, 1,  1, 0));
        vecs.push_back(mk(1, 9,  32'h22,   0, 0,  0,       9, 0,   1, 9,  32'h22,  1, 1,  0, 0));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       9, 0,   0, 9,  32'h11,  0, 1,  0, 0));
        vecs.push_back(mk(1, 4,  32'h44,   1, 4,  32'h40,  4, 0,   1, 4,  32'h44,  1, 1,  0, 0));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       4, 0,   0, 4,  32'h40,  0, 1,  0, 0));
        vecs.push_back(mk(1, 0,  32'h99,   1, 0,  32'h77,  0, 0,   0, 4,  32'h40,  0, 1,  0, 0));
        vecs.push_back(mk(1, 2,  32'h2,    1, 6,  32'h61,  6, 6,   1, 2,  32'h2,   1, 1,  1, 1));
        vecs.push_back(mk(1, 2,  32'h3,    1, 6,  32'h62,  6, 6,   1, 2,  32'h3,   2, 1,  1, 1));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       6, 6,   1, 6,  32'h61,  1, 1,  1, 1));
        vecs.push_back(mk(0, 0,  0,        0, 0,  0,       6, 6,   1, 6,  32'h62,  0, 1,  0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld,
                  vecs[i].r1, vecs[i].r2);
            step;
            chk_out(tag, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].qc);
            chk({tag, " ld_ready"}, 32'(bus.ld_ready), 32'(vecs[i].rdy));
            chk({tag, " pend1"},    32'(bus.pend1),    32'(vecs[i].p1));
            chk({tag, " pend2"},    32'(bus.pend2),    32'(vecs[i].p2));
        end

        // Full FIFO with the ALU busy every cycle; fifth load is held off.
        for (int i = 1; i <= 5; i++) begin
            drive(1, 10, 32'h100 + 32'(i), 1, 5'(10 + i), 32'hB0 + 32'(i), 0, 0);
            #1;
            chk($sformatf("full%0d ld_ready pre", i), 32'(bus.ld_ready), (i <= 4) ? 1 : 0);
            step;
            chk_out($sformatf("full%0d", i), 1, 10, 32'h100 + 32'(i), 3'((i < 4) ? i : 4));
            chk($sformatf("full%0d ld_ready", i), 32'(bus.ld_ready), (i < 4) ? 1 : 0);
        end
        drive(0, 0, 0, 1, 15, 32'hB5, 0, 0);
        #1;
        chk("alu_stop ld_ready pre", 32'(bus.ld_ready), 0);
        step;
        chk_out("alu_stop", 1, 11, 32'hB1, 3);
        chk("alu_stop ld_ready", 32'(bus.ld_ready), 1);
        step;
        chk_out("pushpop", 1, 12, 32'hB2, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 3; i <= 5; i++) begin
            step;
            chk_out($sformatf("drain%0d", i), 1, 5'(10 + i), 32'hB0 + 32'(i), 3'(5 - i));
        end

        // Register-file contents written by the sequences above.
        step;
        chk("rf r5",  rf_model[5],  32'h1234);
        chk("rf r7",  rf_model[7],  32'hAA);
        chk("rf r8",  rf_model[8],  32'h88);
        chk("rf r9",  rf_model[9],  32'h22);
        chk("rf r4",  rf_model[4],  32'h44);
        chk("rf r6",  rf_model[6],  32'h62);
        chk("rf r0",  rf_model[0],  32'h0);
        chk("rf r15", rf_model[15], 32'hB5);

        // Reset mid-queue: three loads queued, reset pulsed between edges.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 20, 32'h200 + 32'(i), 1, 5'(20 + i), 32'hC0 + 32'(i), 0, 0);
            step;
        end
        drive(0, 0, 0, 0, 0, 0, 22, 23);
        #1;
        chk("prerst q_count", 32'(bus.q_count), 3);
        chk("prerst pend1", 32'(bus.pend1), 1);
        chk("prerst pend2", 32'(bus.pend2), 1);
        chk("prerst rf_we", 32'(bus.rf_we), 1);
        #1 reset = 1'b0;
        #1;
        chk_out("midrst", 0, 0, 0, 0);
        chk("midrst ld_ready", 32'(bus.ld_ready), 1);
        chk("midrst pend1", 32'(bus.pend1), 0);
        chk("midrst pend2", 32'(bus.pend2), 0);
        #2 reset = 1'b1;
        step;
        chk_out("postrst", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
